ex_unit: RTL
============

// Module: ex_unit
// PURPOSE
//  Execute stage of the 5-stage in-order LoongArch pipeline, between the decode stage and the memory stage.
//  Computes the ALU result and single-cycle MUL/MULH/MULHU. Runs DIV/MOD/DIVU/MODU on an iterative divider.
//  Issues the data-SRAM request and builds the EX->ME bus, including the load-extract dest_flag code.
//  Drives forwarding and load-use information back to decode.
// PARAMETERS
//  DIV_ITERS  32  divider iterations; the divider is done DIV_ITERS+1 cycles after EX entry.
// PORTS
//  clk              in   1    clock
//  reset            in   1    synchronous, active-high
//  ID_to_EX_Valid   in   1    decode has an instruction for EX
//  ME_Allow_in      in   1    memory stage can accept
//  EX_Allow_in      out  1    !EX_Valid || EX_ReadyGO && ME_Allow_in
//  ID_to_EX_Bus     in   `ID_to_EX_Bus_Size (156); MSB->LSB fields:
//                        syscall1, ertn1, md_op3, alu_op12, mem_signed1, mem_size2, mem_we1,
//                        res_from_mem1, gr_we1, dest5, pc32, src1 32, src2 32, rkd_value32
//  EX_to_ME_Valid   out  1    EX_Valid && EX_ReadyGO
//  EX_to_ME_Bus     out  `EX_to_ME_Bus_Size (78); MSB->LSB fields:
//                        syscall, ertn, dest_flag5, pc, result, res_from_mem, gr_we, dest
//  EX_dest          out  5    dest & {5{EX_Valid & gr_we}}
//  EX_Forward_Res   out  32   EX result (ALU/MUL/DIV)
//  EX_Load_op       out  1    EX_Valid & res_from_mem (load-use stall)
//  ME_Sys_op        in   1    syscall/ertn valid in ME
//  WB_Sys_op        in   1    syscall/ertn valid in WB
//  excp_flush       in   1    exception flush
//  ertn_flush       in   1    ertn flush
//  data_sram_en     out  1    request enable
//  data_sram_we     out  4    byte write enables
//  data_sram_addr   out  32   alu result (src1+src2)
//  data_sram_wdata  out  32   store data, lane-replicated
// BEHAVIOUR
//  - Reset or flush (excp|ertn): EX_Valid=0 next cycle; the divider aborts (busy=0, count=0).
//    All valid/en/we outputs read 0. Flush beats a simultaneous ID_to_EX_Valid.
//  - Bus latch: capture ID_to_EX_Bus when ID_to_EX_Valid && EX_Allow_in.
//    EX_Valid <= ID_to_EX_Valid when EX_Allow_in.
//  - EX_ReadyGO = 1, except for md_op in {DIV,MOD,DIVU,MODU}: then EX_ReadyGO = div_done.
//  - Divider FSM IDLE->BUSY->DONE:
//    - IDLE->BUSY in the entry cycle. One iteration per cycle.
//    - BUSY->DONE after DIV_ITERS iterations; div_done holds in DONE.
//    - DONE->IDLE when handed to ME (EX_to_ME_Valid && ME_Allow_in), or on flush.
//  - Divider results:
//    - Signed ops work on magnitudes; quotient negated if the operand signs differ; remainder takes the dividend sign.
//    - x/0: q=32'hFFFFFFFF, r=x.
//    - 0x80000000/-1 (signed): q=0x80000000, r=0.
//  - MUL: 33x33 signed product, one cycle. MUL takes [31:0]; MULH/MULHU take [63:32]
//    (operands sign- or zero-extended to 33 bits).
//  - mem_size: 00=byte, 01=half, 10=word.
//    dest_flag = {mem_signed, byte, half, addr[1:0]}; word = 5'b00000.
//  - Store byte enables and data:
//    - byte: we = 4'b0001<<addr[1:0], wdata = {4{rkd[7:0]}}.
//    - half: we = addr[1]?4'b1100:4'b0011, wdata = {2{rkd[15:0]}}.
//    - word: we = 4'b1111, wdata = rkd.
//    - Misalignment is out of scope.
//  - cancel = flush | ME_Sys_op | WB_Sys_op | syscall | ertn.
//  - data_sram_en = EX_Valid & EX_ReadyGO & ME_Allow_in & (mem_we|res_from_mem) & ~cancel.
//    The request is issued exactly once, in the hand-off cycle.
//  - data_sram_we = en & mem_we ? mask : 4'b0.
//  - A stall by ME (ME_Allow_in=0) holds all EX state and keeps en low.
// STRUCTURE
//  - Shared my_cpu.vh holds: bus sizes, field offsets, md_op codes (MUL=1,MULH=2,MULHU=3,DIV=4,MOD=5,DIVU=6,MODU=7)
//    and the alu_op one-hot bit indices.
//  - One sub-module, ex_div: FSM, count, restoring shift-subtract, sign fix-up.
//    Interface: start, abort, signed, x, y -> busy, done, q, r.
//  - ALU and MUL stay inline.
// TESTING
//  - ADD src1=5 src2=7, ME_Allow_in=1 -> next cycle EX_to_ME_Valid=1, result=12, EX_dest=dest; no SRAM request.
//  - DIV.W -7/2 -> EX_ReadyGO low cycles 0..32, high at 33; q=-3 (0xFFFFFFFD), MOD r=-1; Allow_in low throughout.
//  - DIVU 5/0 -> q=0xFFFFFFFF, MODU r=5. DIV 0x80000000/-1 -> q=0x80000000.
//  - ST.B addr=0x1003 rkd=0xA5 -> en=1, we=4'b1000, wdata=0xA5A5A5A5.
//    LD.HU addr=0x1002 -> we=0, dest_flag=5'b00110.
//  - ST.W with ME_Sys_op=1 -> en=0, we=0; instruction still passes to ME.
//    MULH 0x80000000*2 -> 0xFFFFFFFF.
//  - excp_flush at DIV cycle 10 -> EX_Valid=0 next cycle, ex_div idle.
//    A following DIV takes the full 33 cycles.

Source files
------------

// File: rtl/ex_unit_pkg.sv
// rtl/ex_unit_pkg.sv - shared bus layouts, md_op codes and alu_op bit indices for the EX stage
// Field order of the packed structs is the MSB->LSB order of the pipeline buses.
package ex_unit_pkg;

  localparam int ID_TO_EX_BUS_SIZE = 156;
  localparam int EX_TO_ME_BUS_SIZE = 78;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MUL   = 3'd1,
    MD_MULH  = 3'd2,
    MD_MULHU = 3'd3,
    MD_DIV   = 3'd4,
    MD_MOD   = 3'd5,
    MD_DIVU  = 3'd6,
    MD_MODU  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic        syscall;
    logic        ertn;
    md_op_e      md_op;
    logic [11:0] alu_op;
    logic        mem_signed;
    mem_size_e   mem_size;
    logic        mem_we;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
  } id_ex_bus_t;

  typedef struct packed {
    logic        syscall;
    logic        ertn;
    logic [4:0]  dest_flag;
    logic [31:0] pc;
    logic [31:0] result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } ex_me_bus_t;

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_MOD) || (op == MD_DIVU) || (op == MD_MODU);
  endfunction

endpackage

// File: rtl/ex_unit_if.sv
// rtl/ex_unit_if.sv - ID->EX and EX->ME handshake/bus bundle
// master is the surrounding pipeline (decode and memory stage), slave is the EX stage.
interface ex_unit_if;

  logic                                    ID_to_EX_Valid;
  logic [ex_unit_pkg::ID_TO_EX_BUS_SIZE-1:0] ID_to_EX_Bus;
  logic                                    EX_Allow_in;
  logic                                    EX_to_ME_Valid;
  logic [ex_unit_pkg::EX_TO_ME_BUS_SIZE-1:0] EX_to_ME_Bus;
  logic                                    ME_Allow_in;

  modport master (
    output ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
    input  EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus
  );

  modport slave (
    input  ID_to_EX_Valid, ID_to_EX_Bus, ME_Allow_in,
    output EX_Allow_in, EX_to_ME_Valid, EX_to_ME_Bus
  );

endinterface

// File: rtl/ex_unit_div.sv
// rtl/ex_unit_div.sv - iterative restoring divider with sign fix-up
// One quotient bit per BUSY cycle; results stay valid in DONE until abort returns it to IDLE.
module ex_unit_div
  import ex_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        signed_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] q_o,
  output logic [31:0] r_o
);

  localparam int            CW   = $clog2(DIV_ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV_ITERS - 1);

  div_state_e    state_q;
  logic [CW-1:0] count_q;
  logic [31:0]   rem_q, quo_q, y_q;
  logic          q_neg_q, r_neg_q, y_zero_q;

  logic          x_neg, y_neg, fits;
  logic [31:0]   x_mag, y_mag, rem_d, quo_d;
  logic [32:0]   shifted;

  always_comb begin
    x_neg   = signed_i & x_i[31];
    y_neg   = signed_i & y_i[31];
    x_mag   = x_neg ? -x_i : x_i;
    y_mag   = y_neg ? -y_i : y_i;
    shifted = {rem_q, quo_q[31]};
    fits    = shifted >= {1'b0, y_q};
    rem_d   = fits ? (shifted[31:0] - y_q) : shifted[31:0];
    quo_d   = {quo_q[30:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset || abort_i) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            state_q  <= DIV_BUSY;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= x_mag;
            y_q      <= y_mag;
            q_neg_q  <= x_neg ^ y_neg;
            r_neg_q  <= x_neg;
            y_zero_q <= (y_i == 32'd0);
          end
        end
        DIV_BUSY: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) state_q <= DIV_DONE;
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero pins the quotient to all ones regardless of sign; the remainder naturally equals x.
  assign busy_o = (state_q == DIV_BUSY);
  assign done_o = (state_q == DIV_DONE);
  assign q_o    = y_zero_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
  assign r_o    = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_unit.sv
// rtl/ex_unit.sv - LoongArch execute stage: ALU, MUL, iterative DIV, data-SRAM request, EX->ME bus
// Forwarding and load-use information is driven back to decode.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  ex_unit_if.slave    pipe,
  output logic [4:0]  EX_dest,
  output logic [31:0] EX_Forward_Res,
  output logic        EX_Load_op,
  input  logic        ME_Sys_op,
  input  logic        WB_Sys_op,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic       ex_valid_q;
  id_ex_bus_t bus_q;
  ex_me_bus_t out_bus;

  logic        flush, is_div, ready_go, handoff, cancel, mul_signed, div_signed;
  logic        div_busy, div_done;
  logic [31:0] a, b, alu_res, result, div_q, div_r, st_wdata;
  logic [63:0] mul_a, mul_b, mul_prod;
  logic [3:0]  st_mask;
  logic [4:0]  dest_flag;

  assign flush    = excp_flush | ertn_flush;
  assign is_div   = is_div_op(bus_q.md_op);
  assign ready_go = ~is_div | div_done;
  assign handoff  = pipe.EX_to_ME_Valid & pipe.ME_Allow_in;

  assign pipe.EX_Allow_in    = ~ex_valid_q | (ready_go & pipe.ME_Allow_in);
  assign pipe.EX_to_ME_Valid = ex_valid_q & ready_go;

  always_ff @(posedge clk) begin
    if (reset || flush) ex_valid_q <= 1'b0;
    else if (pipe.EX_Allow_in) ex_valid_q <= pipe.ID_to_EX_Valid;
  end

  always_ff @(posedge clk) begin
    if (pipe.ID_to_EX_Valid && pipe.EX_Allow_in) bus_q <= id_ex_bus_t'(pipe.ID_to_EX_Bus);
  end

  assign a = bus_q.src1;
  assign b = bus_q.src2;

  always_comb begin
    alu_res = ({32{bus_q.alu_op[ALU_ADD]}}  & (a + b))
            | ({32{bus_q.alu_op[ALU_SUB]}}  & (a - b))
            | ({32{bus_q.alu_op[ALU_SLT]}}  & {31'b0, $signed(a) < $signed(b)})
            | ({32{bus_q.alu_op[ALU_SLTU]}} & {31'b0, a < b})
            | ({32{bus_q.alu_op[ALU_AND]}}  & (a & b))
            | ({32{bus_q.alu_op[ALU_NOR]}}  & ~(a | b))
            | ({32{bus_q.alu_op[ALU_OR]}}   & (a | b))
            | ({32{bus_q.alu_op[ALU_XOR]}}  & (a ^ b))
            | ({32{bus_q.alu_op[ALU_SLL]}}  & (a << b[4:0]))
            | ({32{bus_q.alu_op[ALU_SRL]}}  & (a >> b[4:0]))
            | ({32{bus_q.alu_op[ALU_SRA]}}  & $unsigned($signed(a) >>> b[4:0]))
            | ({32{bus_q.alu_op[ALU_LUI]}}  & b);
  end

  // Extending to 64 bits keeps the low 64 product bits identical to the 33x33 signed product.
  assign mul_signed = (bus_q.md_op != MD_MULHU);
  assign mul_a      = {{32{mul_signed & a[31]}}, a};
  assign mul_b      = {{32{mul_signed & b[31]}}, b};
  assign mul_prod   = mul_a * mul_b;

  assign div_signed = (bus_q.md_op == MD_DIV) || (bus_q.md_op == MD_MOD);

  ex_unit_div #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start_i  (ex_valid_q & is_div & ~div_busy & ~div_done & ~flush),
    .abort_i  (flush | (handoff & is_div)),
    .signed_i (div_signed),
    .x_i      (a),
    .y_i      (b),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .q_o      (div_q),
    .r_o      (div_r)
  );

  always_comb begin
    case (bus_q.md_op)
      MD_MUL:            result = mul_prod[31:0];
      MD_MULH, MD_MULHU: result = mul_prod[63:32];
      MD_DIV, MD_DIVU:   result = div_q;
      MD_MOD, MD_MODU:   result = div_r;
      default:           result = alu_res;
    endcase
  end

  always_comb begin
    st_mask   = 4'b1111;
    st_wdata  = bus_q.rkd_value;
    dest_flag = 5'b00000;
    case (bus_q.mem_size)
      MEM_BYTE: begin
        st_mask   = 4'b0001 << alu_res[1:0];
        st_wdata  = {4{bus_q.rkd_value[7:0]}};
        dest_flag = {bus_q.mem_signed, 1'b1, 1'b0, alu_res[1:0]};
      end
      MEM_HALF: begin
        st_mask   = alu_res[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{bus_q.rkd_value[15:0]}};
        dest_flag = {bus_q.mem_signed, 1'b0, 1'b1, alu_res[1:0]};
      end
      default: ;
    endcase
  end

  // The request fires only in the hand-off cycle so an ME stall never re-issues it.
  assign cancel       = flush | ME_Sys_op | WB_Sys_op | bus_q.syscall | bus_q.ertn;
  assign data_sram_en = ex_valid_q & ready_go & pipe.ME_Allow_in
                      & (bus_q.mem_we | bus_q.res_from_mem) & ~cancel;
  assign data_sram_we    = (data_sram_en & bus_q.mem_we) ? st_mask : 4'b0000;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = st_wdata;

  always_comb begin
    out_bus.syscall      = bus_q.syscall;
    out_bus.ertn         = bus_q.ertn;
    out_bus.dest_flag    = dest_flag;
    out_bus.pc           = bus_q.pc;
    out_bus.result       = result;
    out_bus.res_from_mem = bus_q.res_from_mem;
    out_bus.gr_we        = bus_q.gr_we;
    out_bus.dest         = bus_q.dest;
  end

  assign pipe.EX_to_ME_Bus = out_bus;
  assign EX_dest           = bus_q.dest & {5{ex_valid_q & bus_q.gr_we}};
  assign EX_Forward_Res    = result;
  assign EX_Load_op        = ex_valid_q & bus_q.res_from_mem;

endmodule
